// File: rtl/rst_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_ctrl_pkg
// Description : Shared reset-cause codes, sequencer states and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_ctrl_pkg;

    localparam logic [1:0] RST_CAUSE_POR = 2'd0;
    localparam logic [1:0] RST_CAUSE_EXT = 2'd1;
    localparam logic [1:0] RST_CAUSE_SW  = 2'd2;
    localparam logic [1:0] RST_CAUSE_WDT = 2'd3;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } rst_state_t;

    // Bits needed for a counter that runs 0 .. max_val-1 (never less than 1).
    function automatic int cnt_width(input int max_val);
        return (max_val <= 2) ? 1 : $clog2(max_val);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : rst_sync_debounce
// Description : Synchronises the push-button reset and accepts it only after
//               DEBOUNCE consecutive synchronised-low cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sync_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_rst_n,
    output logic ext_active
);
    import rst_seq_ctrl_pkg::*;

    localparam int                c_DB_W    = cnt_width(DEBOUNCE);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_DB_W-1:0]      r_db_cnt;
    logic                   r_active;
    logic                   w_sync_low;

    assign w_sync_low = ~r_sync[SYNC_STAGES-1];
    assign ext_active = r_active;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync   <= '1;
            r_db_cnt <= '0;
            r_active <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ext_rst_n};
            // Any synchronised-high sample restarts the qualification window.
            if (!w_sync_low) begin
                r_db_cnt <= '0;
                r_active <= 1'b0;
            end else if (!r_active) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_active <= 1'b1;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_ctrl
// Description : Staged multi-domain reset sequencer with button, software and
//               watchdog triggers and a sticky last-reset-cause register.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl #(
    parameter int                   N_DOMAINS   = 3,
    parameter int                   SYNC_STAGES = 2,
    parameter int                   DEBOUNCE    = 4,
    parameter int                   HOLD_CYCLES = 8,
    parameter int                   STAGE_GAP   = 16,
    parameter int                   WDT_WIDTH   = 24,
    parameter logic [WDT_WIDTH-1:0] WDT_TIMEOUT = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ext_rst_n,
    input  logic                 sw_rst_req,
    input  logic                 wdt_en,
    input  logic                 wdt_kick,
    output logic [N_DOMAINS-1:0] sys_rst_o,
    output logic                 busy,
    output logic [1:0]           rst_cause
);
    import rst_seq_ctrl_pkg::*;

    localparam int c_CNT_W = cnt_width((HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP);
    localparam logic [c_CNT_W-1:0]   c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_GAP_LAST  = c_CNT_W'(STAGE_GAP - 1);
    localparam logic [WDT_WIDTH-1:0] c_WDT_LAST  = WDT_TIMEOUT - 1'b1;

    rst_state_t           r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [N_DOMAINS-1:0] r_rst_vec, w_rst_vec_nxt, w_released;
    logic [1:0]           r_cause, w_cause_nxt;
    logic [WDT_WIDTH-1:0] r_wdt_cnt;
    logic                 w_ext_active;
    logic                 w_run;
    logic                 w_wdt_expire;
    logic                 w_trig;

    rst_sync_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE)
    ) u_sync_debounce (
        .clk        (clk),
        .rst        (rst),
        .ext_rst_n  (ext_rst_n),
        .ext_active (w_ext_active)
    );

    assign sys_rst_o = r_rst_vec;
    assign busy      = |r_rst_vec;
    assign rst_cause = r_cause;

    // Domains release lowest index first, so one release is a left shift.
    assign w_released   = r_rst_vec << 1;
    assign w_run        = (r_state == ST_RUN);
    assign w_wdt_expire = w_run && wdt_en && !wdt_kick && (r_wdt_cnt == c_WDT_LAST);
    assign w_trig       = w_ext_active || w_wdt_expire || sw_rst_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_ASSERT;
            r_cnt     <= '0;
            r_rst_vec <= '1;
            r_cause   <= RST_CAUSE_POR;
            r_wdt_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rst_vec <= w_rst_vec_nxt;
            r_cause   <= w_cause_nxt;
            if (!w_run || !wdt_en || wdt_kick || w_wdt_expire) begin
                r_wdt_cnt <= '0;
            end else begin
                r_wdt_cnt <= r_wdt_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rst_vec_nxt = r_rst_vec;
        w_cause_nxt   = r_cause;
        case (r_state)
            ST_ASSERT: begin
                w_rst_vec_nxt = '1;
                w_cnt_nxt     = '0;
                if (!w_ext_active) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD, ST_RELEASE: begin
                if (w_ext_active) begin
                    w_state_nxt   = ST_ASSERT;
                    w_rst_vec_nxt = '1;
                    w_cnt_nxt     = '0;
                    w_cause_nxt   = RST_CAUSE_EXT;
                end else if (r_cnt == ((r_state == ST_HOLD) ? c_HOLD_LAST : c_GAP_LAST)) begin
                    w_rst_vec_nxt = w_released;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = (w_released == '0) ? ST_RUN : ST_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (w_trig) begin
                    w_state_nxt   = ST_ASSERT;
                    w_rst_vec_nxt = '1;
                    w_cnt_nxt     = '0;
                    if (w_ext_active) begin
                        w_cause_nxt = RST_CAUSE_EXT;
                    end else if (w_wdt_expire) begin
                        w_cause_nxt = RST_CAUSE_WDT;
                    end else begin
                        w_cause_nxt = RST_CAUSE_SW;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_ASSERT;
                w_rst_vec_nxt = '1;
                w_cnt_nxt     = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_seq_ctrl
// Description : Directed self-checking bench for rst_seq_ctrl (WDT_TIMEOUT=100).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       ext_rst_n;
    logic       sw_rst_req;
    logic       wdt_en;
    logic       wdt_kick;
    logic [2:0] sys_rst_o;
    logic       busy;
    logic [1:0] rst_cause;

    int n_checks = 0;
    int n_err    = 0;

    rst_seq_ctrl #(
        .N_DOMAINS   (3),
        .SYNC_STAGES (2),
        .DEBOUNCE    (4),
        .HOLD_CYCLES (8),
        .STAGE_GAP   (16),
        .WDT_WIDTH   (24),
        .WDT_TIMEOUT (24'd100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ext_rst_n  (ext_rst_n),
        .sw_rst_req (sw_rst_req),
        .wdt_en     (wdt_en),
        .wdt_kick   (wdt_kick),
        .sys_rst_o  (sys_rst_o),
        .busy       (busy),
        .rst_cause  (rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called 1 ns after T0 (first edge in HOLD); returns 1 ns after T0+40.
    task automatic seq_check(input string tag);
        chk({tag, " T0"},    32'(sys_rst_o), 32'h7);
        step(7);
        chk({tag, " T0+7"},  32'(sys_rst_o), 32'h7);
        step(1);
        chk({tag, " T0+8"},  32'(sys_rst_o), 32'h6);
        step(15);
        chk({tag, " T0+23"}, 32'(sys_rst_o), 32'h6);
        step(1);
        chk({tag, " T0+24"}, 32'(sys_rst_o), 32'h4);
        step(15);
        chk({tag, " T0+39"}, 32'(sys_rst_o), 32'h4);
        chk({tag, " busy T0+39"}, 32'(busy), 32'h1);
        step(1);
        chk({tag, " T0+40"}, 32'(sys_rst_o), 32'h0);
        chk({tag, " busy T0+40"}, 32'(busy), 32'h0);
    endtask

    initial begin
        rst        = 1'b0;
        ext_rst_n  = 1'b1;
        sw_rst_req = 1'b0;
        wdt_en     = 1'b0;
        wdt_kick   = 1'b0;

        // Power-on
        step(5);
        chk("por sys",   32'(sys_rst_o), 32'h7);
        chk("por busy",  32'(busy),      32'h1);
        chk("por cause", 32'(rst_cause), 32'h0);
        rst = 1'b1;
        step(1);
        seq_check("por");
        chk("por cause run", 32'(rst_cause), 32'h0);

        // Software reset in RUN
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        chk("sw assert", 32'(sys_rst_o), 32'h7);
        chk("sw cause",  32'(rst_cause), 32'h2);
        step(1);
        seq_check("sw");

        // Software pulse during RELEASE is ignored
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        step(1);
        step(10);
        chk("swrel T0+10", 32'(sys_rst_o), 32'h6);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        chk("swrel ignored", 32'(sys_rst_o), 32'h6);
        step(13);
        chk("swrel T0+24", 32'(sys_rst_o), 32'h4);
        step(16);
        chk("swrel T0+40", 32'(sys_rst_o), 32'h0);

        // Button held 20 cycles in RUN
        ext_rst_n = 1'b0;
        step(6);
        chk("btn E6", 32'(sys_rst_o), 32'h0);
        step(1);
        chk("btn E7",       32'(sys_rst_o), 32'h7);
        chk("btn cause",    32'(rst_cause), 32'h1);
        step(13);
        chk("btn E20", 32'(sys_rst_o), 32'h7);
        ext_rst_n = 1'b1;
        step(3);
        chk("btn E23", 32'(sys_rst_o), 32'h7);
        step(1);
        seq_check("btn");
        chk("btn cause run", 32'(rst_cause), 32'h1);

        // 3-cycle glitch is filtered
        ext_rst_n = 1'b0;
        step(3);
        ext_rst_n = 1'b1;
        step(20);
        chk("glitch sys",   32'(sys_rst_o), 32'h0);
        chk("glitch cause", 32'(rst_cause), 32'h1);

        // Watchdog expiry, no kicks
        wdt_en = 1'b1;
        step(99);
        chk("wdt before", 32'(sys_rst_o), 32'h0);
        step(1);
        chk("wdt fire",  32'(sys_rst_o), 32'h7);
        chk("wdt cause", 32'(rst_cause), 32'h3);
        step(1);
        seq_check("wdt");

        // Kicks every 50 cycles for 1000 cycles
        for (int i = 0; i < 20; i++) begin
            step(49);
            wdt_kick = 1'b1;
            step(1);
            wdt_kick = 1'b0;
        end
        chk("kick50 sys", 32'(sys_rst_o), 32'h0);

        // Kick coincident with count 99, then expiry racing a software request
        step(99);
        wdt_kick = 1'b1;
        step(1);
        wdt_kick = 1'b0;
        chk("kick99 sys", 32'(sys_rst_o), 32'h0);
        step(99);
        chk("wdt2 before", 32'(sys_rst_o), 32'h0);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        chk("wdt2 fire",  32'(sys_rst_o), 32'h7);
        chk("wdt>sw cause", 32'(rst_cause), 32'h3);
        wdt_en = 1'b0;

        // Block reset mid-sequence at T0+20
        step(1);
        step(19);
        chk("mid T0+19", 32'(sys_rst_o), 32'h6);
        rst = 1'b0;
        step(1);
        chk("mid sys",   32'(sys_rst_o), 32'h7);
        chk("mid busy",  32'(busy),      32'h1);
        chk("mid cause", 32'(rst_cause), 32'h0);
        rst = 1'b1;
        step(1);
        seq_check("mid");

        // Button during RELEASE restarts the sequence
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        step(1);
        step(12);
        ext_rst_n = 1'b0;
        step(6);
        chk("btnrel E6", 32'(sys_rst_o), 32'h6);
        ext_rst_n = 1'b1;
        step(1);
        chk("btnrel E7",    32'(sys_rst_o), 32'h7);
        chk("btnrel cause", 32'(rst_cause), 32'h1);
        step(2);
        chk("btnrel E9", 32'(sys_rst_o), 32'h7);
        step(1);
        seq_check("btnrel");
        chk("btnrel cause run", 32'(rst_cause), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
